// File: rtl/comb_filter_param_if.sv
// Frame-level port bundle of the stereo comb filter: per-strobe control and audio in,
// filtered audio and status out. The filter itself connects through the slave modport.
interface comb_filter_param_if #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 10
);
    logic                  sample_en;
    logic [ADDR_W-1:0]     delay;
    logic                  mode;
    logic                  subtract;
    logic                  bypass;
    logic [2*SAMPLE_W-1:0] audioIn;
    logic [2*SAMPLE_W-1:0] audioOut;
    logic                  out_valid;
    logic                  overrun;

    modport master (
        output sample_en, delay, mode, subtract, bypass, audioIn,
        input  audioOut, out_valid, overrun
    );

    modport slave (
        input  sample_en, delay, mode, subtract, bypass, audioIn,
        output audioOut, out_valid, overrun
    );
endinterface

// File: rtl/comb_filter_param.sv
// Stereo comb filter with a run-time delay held in a circular frame buffer; each frame
// takes IDLE -> READ -> WRITE, in either feed-forward or feedback form.
module comb_filter_param #(
    parameter int SAMPLE_W   = 16,
    parameter int MAX_DELAY  = 1024,
    parameter int ADDR_W     = 10,
    parameter int GAIN_SHIFT = 1
) (
    input logic                clk,
    input logic                rst,
    comb_filter_param_if.slave bus
);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int FILL_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   x_q, x_d;
    logic [ADDR_W-1:0]    dly_q, dly_d;
    logic                 mode_q, mode_d;
    logic                 sub_q, sub_d;
    logic                 byp_q, byp_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [FRAME_W-1:0]   sat_q, sat_d;
    logic [FRAME_W-1:0]   out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;

    logic [FRAME_W-1:0]   mem [MAX_DELAY];
    logic [FRAME_W-1:0]   rd_data_q;
    logic                 rd_en;
    logic                 wr_en;
    logic [ADDR_W-1:0]    dly_eff;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 hist_ok;
    logic [FRAME_W-1:0]   sat_w;
    logic [FRAME_W-1:0]   wr_data;

    // x +/- (w >>> GAIN_SHIFT) in SAMPLE_W+1 bits, clamped back to SAMPLE_W.
    function automatic logic [SAMPLE_W-1:0] chan_sum(
        input logic [SAMPLE_W-1:0] x,
        input logic [SAMPLE_W-1:0] w,
        input logic                use_w,
        input logic                sub
    );
        logic signed [SAMPLE_W:0] xe;
        logic signed [SAMPLE_W:0] we;
        logic signed [SAMPLE_W:0] de;
        logic signed [SAMPLE_W:0] s;
        xe = {x[SAMPLE_W-1], x};
        we = {w[SAMPLE_W-1], w};
        de = we >>> GAIN_SHIFT;
        if (!use_w) begin
            de = '0;
        end
        s = sub ? (xe - de) : (xe + de);
        if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
            return s[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return s[SAMPLE_W-1:0];
    endfunction

    assign dly_eff = (bus.delay == '0) ? ADDR_W'(1) : bus.delay;
    // MAX_DELAY is a power of two, so the natural ADDR_W wrap is the modulo.
    assign rd_addr = wr_ptr_q - dly_eff;
    assign hist_ok = (fill_q >= {1'b0, dly_q});

    assign sat_w = {chan_sum(x_q[FRAME_W-1:SAMPLE_W], rd_data_q[FRAME_W-1:SAMPLE_W], hist_ok, sub_q),
                    chan_sum(x_q[SAMPLE_W-1:0],       rd_data_q[SAMPLE_W-1:0],       hist_ok, sub_q)};

    assign wr_data = mode_q ? sat_q : x_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        dly_d       = dly_q;
        mode_d      = mode_q;
        sub_d       = sub_q;
        byp_d       = byp_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        sat_d       = sat_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;

        if (bus.sample_en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.sample_en) begin
                    x_d     = bus.audioIn;
                    dly_d   = dly_eff;
                    mode_d  = bus.mode;
                    sub_d   = bus.subtract;
                    byp_d   = bus.bypass;
                    rd_en   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                sat_d       = sat_w;
                out_d       = byp_q ? x_q : sat_w;
                out_valid_d = 1'b1;
                state_d     = WRITE;
            end
            WRITE: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (fill_q != FILL_W'(MAX_DELAY)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            dly_q       <= ADDR_W'(1);
            mode_q      <= 1'b0;
            sub_q       <= 1'b0;
            byp_q       <= 1'b0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            sat_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            dly_q       <= dly_d;
            mode_q      <= mode_d;
            sub_q       <= sub_d;
            byp_q       <= byp_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            sat_q       <= sat_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: the buffer is deliberately not reset; fill_q decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign bus.audioOut  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_comb_filter_param.sv
// Bench for comb_filter_param: two instances (no gain, depth 8; half gain, depth 16) share
// stimulus, and a frame-history model feeds per-instance expectation queues.
module tb_comb_filter_param;
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_acc = -1000;

    exp_t        exq  [2][$];
    logic [31:0] hist [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comb_filter_param_if #(.SAMPLE_W(16), .ADDR_W(3)) if0 ();
    comb_filter_param_if #(.SAMPLE_W(16), .ADDR_W(4)) if1 ();

    comb_filter_param #(.SAMPLE_W(16), .MAX_DELAY(8), .ADDR_W(3), .GAIN_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    comb_filter_param #(.SAMPLE_W(16), .MAX_DELAY(16), .ADDR_W(4), .GAIN_SHIFT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // One channel from first principles: y = x +/- g*h, g = 2^-gs, clamped to 16-bit range.
    function automatic logic [15:0] chan_model(input logic [15:0] x, input logic [15:0] h,
                                               input bit have, input int gs, input bit sub);
        int xi, di, s;
        xi = int'($signed(x));
        di = have ? (int'($signed(h)) >>> gs) : 0;
        s  = sub ? xi - di : xi + di;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic model_accept(input logic [31:0] x, input logic [3:0] del,
                                input bit m, input bit sub, input bit byp);
        for (int k = 0; k < 2; k++) begin
            int          d, n;
            bit          have;
            logic [31:0] h, sat;
            exp_t        e;
            d = (k == 0) ? int'(del[2:0]) : int'(del);
            if (d == 0) d = 1;
            n    = hist[k].size();
            have = (n >= d);
            h    = have ? hist[k][n-d] : 32'h0;
            sat  = {chan_model(x[31:16], h[31:16], have, k, sub),
                    chan_model(x[15:0],  h[15:0],  have, k, sub)};
            e.data = byp ? x : sat;
            e.due  = cyc + 2;
            exq[k].push_back(e);
            hist[k].push_back(m ? sat : x);
        end
    endtask

    task automatic set_inputs(input logic [31:0] x, input logic [3:0] del,
                              input bit m, input bit sub, input bit byp);
        if0.audioIn = x;   if1.audioIn = x;
        if0.delay = del[2:0]; if1.delay = del;
        if0.mode = m;      if1.mode = m;
        if0.subtract = sub; if1.subtract = sub;
        if0.bypass = byp;  if1.bypass = byp;
    endtask

    task automatic send(input logic [31:0] x, input logic [3:0] del, input bit m,
                        input bit sub, input bit byp, input int gap);
        @(posedge clk); #1;
        set_inputs(x, del, m, sub, byp);
        if0.sample_en = 1'b1; if1.sample_en = 1'b1;
        if (cyc - last_acc >= 3) begin
            model_accept(x, del, m, sub, byp);
            last_acc = cyc;
        end
        @(posedge clk); #1;
        if0.sample_en = 1'b0; if1.sample_en = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            exq[k].delete();
            hist[k].delete();
        end
        last_acc = -1000;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        if0.sample_en = 1'b0; if1.sample_en = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic impulse_ff();
        for (int f = 0; f < 10; f++)
            send((f == 0) ? {16'd1000, 16'd0} : 32'h0, 4'd4, 1'b0, 1'b1, 1'b0, 3);
    endtask

    // Scoreboard monitor: every out_valid pulse pops one expectation and checks data and latency.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        v;
            logic [31:0] d;
            exp_t        e;
            v = (k == 0) ? if0.out_valid : if1.out_valid;
            d = (k == 0) ? if0.audioOut  : if1.audioOut;
            if (v === 1'b1) begin
                if (exq[k].size() == 0) begin
                    fail_now($sformatf("unexpected_out_valid_dut%0d", k));
                end else begin
                    e = exq[k].pop_front();
                    check($sformatf("audio_out_dut%0d", k), d, e.data);
                    check($sformatf("latency_dut%0d", k), 32'(cyc), 32'(e.due));
                end
            end else if (exq[k].size() != 0 && cyc > exq[k][0].due) begin
                fail_now($sformatf("missing_out_valid_dut%0d", k));
                void'(exq[k].pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.sample_en = 1'b0; if1.sample_en = 1'b0;
        set_inputs(32'h0, 4'd1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_audio_out_dut0", if0.audioOut, 32'h0);
        check("rst_audio_out_dut1", if1.audioOut, 32'h0);
        check("rst_out_valid_dut0", {31'h0, if0.out_valid}, 32'h0);
        check("rst_out_valid_dut1", {31'h0, if1.out_valid}, 32'h0);
        check("rst_overrun_dut0", {31'h0, if0.overrun}, 32'h0);
        check("rst_overrun_dut1", {31'h0, if1.overrun}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        impulse_ff();

        do_reset();
        for (int f = 0; f < 12; f++)
            send((f == 0) ? {16'd16384, 16'd0} : 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 3);

        do_reset();
        for (int f = 0; f < 20; f++)
            send({16'd500, 16'd500}, 4'd7, 1'b0, 1'b1, 1'b0, 3);

        send({16'h8AD0, 16'h0}, 4'd1, 1'b0, 1'b1, 1'b0, 3);
        send({16'h7530, 16'h0}, 4'd1, 1'b0, 1'b1, 1'b0, 3);
        @(negedge clk);
        check("sat_pos_dut0", if0.audioOut, 32'h7FFF_0000);
        check("sat_pos_dut1", if1.audioOut, 32'h7FFF_0000);
        send({16'h7530, 16'h0}, 4'd1, 1'b0, 1'b1, 1'b0, 3);
        send({16'h8AD0, 16'h0}, 4'd1, 1'b0, 1'b1, 1'b0, 3);
        @(negedge clk);
        check("sat_neg_dut0", if0.audioOut, 32'h8000_0000);
        check("sat_neg_dut1", if1.audioOut, 32'h8000_0000);

        send(32'h1234_ABCD, 4'd2, 1'b1, 1'b0, 1'b1, 3);
        @(negedge clk);
        check("bypass_dut0", if0.audioOut, 32'h1234_ABCD);
        check("bypass_dut1", if1.audioOut, 32'h1234_ABCD);

        for (int f = 0; f < 150; f++) begin
            logic [31:0] x;
            x = $urandom;
            if ($urandom_range(0, 3) == 0) x[31:16] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
            send(x, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), $urandom_range(3, 5));
        end

        send({16'd77, 16'd99}, 4'd2, 1'b0, 1'b0, 1'b0, 2);
        send({16'd11, 16'd22}, 4'd2, 1'b0, 1'b0, 1'b0, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("overrun_set_dut0", {31'h0, if0.overrun}, 32'h1);
        check("overrun_set_dut1", {31'h0, if1.overrun}, 32'h1);
        send({16'd5, 16'd6}, 4'd2, 1'b0, 1'b0, 1'b0, 4);
        @(negedge clk);
        check("overrun_sticky_dut0", {31'h0, if0.overrun}, 32'h1);
        check("overrun_sticky_dut1", {31'h0, if1.overrun}, 32'h1);

        // Abort a frame by resetting during its READ cycle; the aborted frame expects nothing.
        @(posedge clk); #1;
        set_inputs({16'd4321, 16'd1234}, 4'd1, 1'b0, 1'b1, 1'b0);
        if0.sample_en = 1'b1; if1.sample_en = 1'b1;
        @(posedge clk); #1;
        if0.sample_en = 1'b0; if1.sample_en = 1'b0;
        rst = 1'b1;
        clear_model();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid_dut0", {31'h0, if0.out_valid}, 32'h0);
        check("midrst_out_valid_dut1", {31'h0, if1.out_valid}, 32'h0);
        check("midrst_audio_out_dut0", if0.audioOut, 32'h0);
        check("midrst_audio_out_dut1", if1.audioOut, 32'h0);
        check("midrst_overrun_dut0", {31'h0, if0.overrun}, 32'h0);
        check("midrst_overrun_dut1", {31'h0, if1.overrun}, 32'h0);

        impulse_ff();

        repeat (8) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("queue_drained_dut%0d", k), 32'(exq[k].size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/comb_filter_param.md
# comb_filter_param

Parametrised stereo comb filter for the audio datapath. It sits between the codec receive path and the DAC transmit path, processing one packed stereo frame per `sample_en` strobe. The delay length is set at run time up to `MAX_DELAY` frames and held in a circular buffer. Each channel runs in feed-forward mode (`y = x ∓ g·x[n−D]`) or feedback mode (`y = x ± g·y[n−D]`), with power-of-two gain, saturating arithmetic, bypass, and overrun detection.

## Interface
- `SAMPLE_W`, default 16: bits per channel sample, two's complement.
- `MAX_DELAY`, default 1024: circular buffer depth in frames; must be a power of two.
- `ADDR_W`, default 10: log2(`MAX_DELAY`).
- `GAIN_SHIFT`, default 1: the delayed term is arithmetically right-shifted by this amount (g = 2^−GAIN_SHIFT).

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_en`  in  1  one-cycle strobe; a new frame is present on `audioIn`.
- `delay`  in  ADDR_W  delay D in frames; 0 is treated as 1.
- `mode`  in  1  0 = feed-forward, 1 = feedback.
- `subtract`  in  1  1 = delayed term is subtracted, 0 = added.
- `bypass`  in  1  1 = `audioOut` takes `audioIn` unmodified; the buffer still updates.
- `audioIn`  in  2*SAMPLE_W  left in `[2*SAMPLE_W-1:SAMPLE_W]`, right in `[SAMPLE_W-1:0]`.
- `audioOut`  out  2*SAMPLE_W  filtered frame, same packing; registered.
- `out_valid`  out  1  one-cycle pulse when `audioOut` updates.
- `overrun`  out  1  sticky; set by a strobe arriving while busy, cleared only by `rst`.

## Operation
- The FSM has three states: IDLE, READ, WRITE.
- **IDLE:** on `sample_en`, latch `audioIn`, `delay` (0 becomes 1), `mode`, `subtract` and `bypass`. Issue a synchronous buffer read at `(wr_ptr − D) mod MAX_DELAY`. Go to READ.
- **READ:** per channel:
  - d = buffer word, sign-extended, then `>>> GAIN_SHIFT`.
  - If `fill < D`, force d = 0, so history from before reset is never heard.
  - s = x ± d, computed in SAMPLE_W+1 bits.
  - Saturate s to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1].
  - Register the result (or x when `bypass`) into `audioOut`. Go to WRITE.
- **WRITE:** pulse `out_valid`. Write the buffer word at `wr_ptr`: x in feed-forward mode, the saturated s in feedback mode (s is stored even when `bypass`). Increment `wr_ptr` with wrap at `MAX_DELAY`. Increment `fill`, saturating at `MAX_DELAY`. Return to IDLE.
- Buffer word = 2*SAMPLE_W bits, one word per frame, single-port-read/single-port-write RAM with registered read. Contents are not cleared by reset; validity is tracked by `fill` only.
- Changes to `delay`, `mode` or `subtract` take effect at the next strobe. Buffer contents are kept: after a mode change, old words are reinterpreted under the new mode.
- Left and right are processed in parallel with identical control. There is no cross-channel interaction.

## Timing
- Reset values: `audioOut` = 0, `out_valid` = 0, `overrun` = 0, `wr_ptr` = 0, `fill` = 0, state = IDLE.
- Latency: strobe in cycle t gives `audioOut` valid and `out_valid` = 1 in cycle t+2. `audioOut` holds until the next update.
- Minimum strobe spacing is 3 cycles.
- A `sample_en` seen in READ or WRITE is dropped (no latch, no pointer change) and sets `overrun`.
- A `sample_en` in the same cycle as the WRITE→IDLE transition counts as busy.
- `rst` asserted mid-frame aborts the frame: no `out_valid`, no buffer write, and all registers return to their reset values on the next edge.
- Wrap-around: with `wr_ptr` = MAX_DELAY−1 and D = 2, the read address is MAX_DELAY−3. The next write lands at MAX_DELAY−1, then `wr_ptr` = 0.
- D ≥ `MAX_DELAY` is impossible by width. D = MAX_DELAY−1 is the longest legal delay.

## Test plan
- **Feed-forward impulse:** mode=0, subtract=1, GAIN_SHIFT=0, D=4; left input 1000 on frame 0, then zeros → left output 1000 on frame 0, −1000 on frame 4, 0 on all other frames. Right output is 0 throughout. Each `out_valid` appears 2 cycles after its strobe.
- **Feedback decay:** mode=1, subtract=0, GAIN_SHIFT=1, D=3; impulse 16384 → outputs 16384, 8192, 4096, 2048 on frames 0, 3, 6, 9, and 0 elsewhere.
- **Saturation:** mode=0, subtract=1, GAIN_SHIFT=0, D=1; frames −30000 then 30000 → second output = 32767. Swapping the signs of both frames → −32768.
- **Pre-fill and wrap:** MAX_DELAY=8, D=7, constant input 500, feed-forward subtract, GAIN_SHIFT=0 → 500 for frames 0–6, 0 from frame 7 on. Running 20 frames exercises `wr_ptr` wrap with no glitch.
- **Overrun and bypass:** strobes 2 cycles apart → second strobe dropped, `overrun` = 1 and stays high, 1 `out_valid` pulse only. With `bypass` = 1 and input 0x1234_ABCD → output 0x1234_ABCD.
- **Reset mid-operation:** assert `rst` in the READ cycle → no `out_valid`, `audioOut` = 0, `fill` = 0. After reset, the next impulse behaves exactly as in the feed-forward impulse test.
